comm_frame_arbiter: RTL and testbench
=====================================

// Module: comm_frame_arbiter
// PURPOSE
//  Frame-level arbiter between the two redundant command receivers (comm A/B UART RX FIFOs).
//  Detects frame end by inter-byte idle gap, picks the port that delivered more bytes, drains that
//  frame to the command module over valid/ready, and flushes the other port's copy of the frame.
//  Sits between the comm_A/comm_B uart instances and the command decoder inside core.
// PARAMETERS
//  CNT_W       5       width of UART RX FIFO count (UART_FIFO_COUNTER_W)
//  GAP_CYCLES  20000   idle clocks with no push on either port that end a frame (>=2)
//  NUM_W       10      width of per-frame byte counters (saturating)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      asynchronous active-low reset
//  push_a       in   1      comm A rf_push_pulse, 1 clk per received byte
//  push_b       in   1      comm B rf_push_pulse
//  count_a      in   CNT_W  comm A rf_count
//  count_b      in   CNT_W  comm B rf_count
//  rdr_a        in   8      comm A FIFO head byte
//  rdr_b        in   8      comm B FIFO head byte
//  pop_a        out  1      comm A rf_pop, 1-clk pulse
//  pop_b        out  1      comm B rf_pop, 1-clk pulse
//  cmd_data     out  8      frame byte to command module
//  cmd_valid    out  1      cmd_data valid
//  cmd_ready    in   1      command module accepts byte
//  cmd_last     out  1      qualifies final byte of frame (with cmd_valid)
//  sel          out  1      port of last decided frame: 0=A, 1=B
//  busy         out  1      high in any state except IDLE
//  frame_err    out  1      1-clk pulse: selected port snapshot count was 0
// BEHAVIOUR
//  Reset: all outputs 0, sel=0, state IDLE, all counters 0. FIFO contents untouched.
//  Counters: num_a/num_b count pushes (saturate at 2^NUM_W-1); idle_cnt counts clks with no push.
//   Counting runs in every state; num_a/num_b cleared in DECIDE (a push that same clk counts as 1).
//  IDLE: any push -> RECV (that push counted, idle_cnt=0).
//  RECV: push on either port clears idle_cnt; else idle_cnt+1. idle_cnt==GAP_CYCLES-1 -> DECIDE.
//  DECIDE (1 clk): sel<=0 if num_a>num_b, 1 if num_b>num_a, unchanged on tie.
//   Snapshot len<=count of new sel port, flen<=count of other port.
//   len==0 -> pulse frame_err, go FLUSH; else -> LOAD.
//  LOAD (1 clk): cmd_data<=selected rdr, cmd_valid<=1, cmd_last<=(len==1) -> PRESENT.
//  PRESENT: hold cmd_data/cmd_last stable while cmd_valid && !cmd_ready.
//   On cmd_valid&&cmd_ready: cmd_valid<=0, cmd_last<=0, 1-clk pop on selected port, len-1 -> WAIT.
//  WAIT (1 clk, covers FIFO count/rdr update latency): len==0 -> FLUSH, else LOAD.
//   Throughput: max 1 byte / 3 clks.
//  FLUSH: flen==0 -> END. Else pulse pop on non-selected port, flen-1, -> FWAIT (1 clk) -> FLUSH.
//  END: pushes seen since DECIDE (num_a|num_b != 0) -> RECV (idle_cnt kept running), else IDLE.
//  Only snapshotted lengths are drained/flushed; bytes of a next frame arriving mid-drain stay queued.
//  pop_a and pop_b never high in same clk; never pop in IDLE/RECV/DECIDE.
//  Async reset mid-operation aborts frame immediately, with no further pops; command module discards partial frame.
// TESTING
//  5 bytes on A, same 5 bytes on B, then GAP_CYCLES idle -> tie, sel stays 0; 5 bytes out via A,
//   last has cmd_last=1; then 5 pop_b pulses; busy drops.
//  A gets 3 bytes, B gets 6 (A line noisy) -> sel=1; 6 bytes from B out in order; 3 pop_a flushes.
//  cmd_ready held low 50 clks on byte 2 -> cmd_data stable, no pop until ready; byte 3 then follows.
//  Second frame pushed on A during drain of first -> first frame ends at its snapshot length;
//   FSM returns to RECV; second frame decided after the gap.
//  Idle of GAP_CYCLES-2 between bytes -> still one frame; GAP_CYCLES exactly -> frame split.
//  rst_n low while in PRESENT -> pops/cmd_valid/busy/sel all 0 same clk; no pops after release.

Source files
------------

// File: rtl/comm_frame_arbiter.sv
// Frame-level arbiter for the redundant comm A/B receivers: ends a frame on an idle gap,
// forwards the longer copy to the command decoder and flushes the other copy.
module comm_frame_arbiter #(
  parameter int CNT_W      = 5,
  parameter int GAP_CYCLES = 20000,
  parameter int NUM_W      = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_a,
  input  logic             push_b,
  input  logic [CNT_W-1:0] count_a,
  input  logic [CNT_W-1:0] count_b,
  input  logic [7:0]       rdr_a,
  input  logic [7:0]       rdr_b,
  output logic             pop_a,
  output logic             pop_b,
  output logic [7:0]       cmd_data,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_last,
  output logic             sel,
  output logic             busy,
  output logic             frame_err
);

  localparam int IDW = $clog2(GAP_CYCLES + 1);
  localparam logic [IDW-1:0]   GAP_LAST = IDW'(GAP_CYCLES - 1);
  localparam logic [IDW-1:0]   IDLE_MAX = '1;
  localparam logic [NUM_W-1:0] NUM_MAX  = '1;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_RECV    = 4'd1;
  localparam logic [3:0] ST_DECIDE  = 4'd2;
  localparam logic [3:0] ST_LOAD    = 4'd3;
  localparam logic [3:0] ST_PRESENT = 4'd4;
  localparam logic [3:0] ST_WAIT    = 4'd5;
  localparam logic [3:0] ST_FLUSH   = 4'd6;
  localparam logic [3:0] ST_FWAIT   = 4'd7;
  localparam logic [3:0] ST_END     = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [NUM_W-1:0] num_a_q, num_a_d, num_b_q, num_b_d;
  logic [IDW-1:0]   idle_q, idle_d;
  logic [CNT_W-1:0] len_q, len_d, flen_q, flen_d;
  logic             sel_q, sel_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d, last_q, last_d;
  logic             pop_a_q, pop_a_d, pop_b_q, pop_b_d;
  logic             err_q, err_d;

  logic             any_push;
  logic             sel_new;
  logic [CNT_W-1:0] sel_count, oth_count;

  assign any_push  = push_a | push_b;
  assign sel_new   = (num_a_q > num_b_q) ? 1'b0 : ((num_b_q > num_a_q) ? 1'b1 : sel_q);
  assign sel_count = sel_new ? count_b : count_a;
  assign oth_count = sel_new ? count_a : count_b;

  // Push and idle counters run in every state; DECIDE restarts the per-frame counts so a
  // push landing on the decision clock already belongs to the next frame.
  always_comb begin
    num_a_d = num_a_q;
    num_b_d = num_b_q;
    if (state_q == ST_DECIDE) begin
      num_a_d = {{(NUM_W-1){1'b0}}, push_a};
      num_b_d = {{(NUM_W-1){1'b0}}, push_b};
    end else begin
      if (push_a && num_a_q != NUM_MAX) num_a_d = num_a_q + NUM_W'(1);
      if (push_b && num_b_q != NUM_MAX) num_b_d = num_b_q + NUM_W'(1);
    end
    idle_d = any_push ? '0 : ((idle_q == IDLE_MAX) ? idle_q : idle_q + IDW'(1));
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    len_d   = len_q;
    flen_d  = flen_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    pop_a_d = 1'b0;
    pop_b_d = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: if (any_push) state_d = ST_RECV;
      ST_RECV: if (!any_push && idle_q >= GAP_LAST) state_d = ST_DECIDE;
      ST_DECIDE: begin
        sel_d  = sel_new;
        len_d  = sel_count;
        flen_d = oth_count;
        if (sel_count == '0) begin
          err_d   = 1'b1;
          state_d = ST_FLUSH;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        data_d  = sel_q ? rdr_b : rdr_a;
        valid_d = 1'b1;
        last_d  = (len_q == CNT_W'(1));
        state_d = ST_PRESENT;
      end
      ST_PRESENT: if (valid_q && cmd_ready) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
        pop_a_d = ~sel_q;
        pop_b_d = sel_q;
        len_d   = len_q - CNT_W'(1);
        state_d = ST_WAIT;
      end
      // One spare clock lets the FIFO count and head byte settle after a pop.
      ST_WAIT: state_d = (len_q == '0) ? ST_FLUSH : ST_LOAD;
      ST_FLUSH: begin
        if (flen_q == '0) begin
          state_d = ST_END;
        end else begin
          pop_a_d = sel_q;
          pop_b_d = ~sel_q;
          flen_d  = flen_q - CNT_W'(1);
          state_d = ST_FWAIT;
        end
      end
      ST_FWAIT: state_d = ST_FLUSH;
      ST_END:   state_d = (num_a_q != '0 || num_b_q != '0) ? ST_RECV : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      num_a_q <= '0;
      num_b_q <= '0;
      idle_q  <= '0;
      len_q   <= '0;
      flen_q  <= '0;
      sel_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      pop_a_q <= 1'b0;
      pop_b_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      num_a_q <= num_a_d;
      num_b_q <= num_b_d;
      idle_q  <= idle_d;
      len_q   <= len_d;
      flen_q  <= flen_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      pop_a_q <= pop_a_d;
      pop_b_q <= pop_b_d;
      err_q   <= err_d;
    end
  end

  assign pop_a     = pop_a_q;
  assign pop_b     = pop_b_q;
  assign cmd_data  = data_q;
  assign cmd_valid = valid_q;
  assign cmd_last  = last_q;
  assign sel       = sel_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_err = err_q;

endmodule

// File: tb/tb_comm_frame_arbiter.sv
// Self-checking bench for comm_frame_arbiter: behavioural UART FIFO models on both ports,
// a frame-level reference model and randomized bytes, gaps and cmd_ready back-pressure.
module tb_comm_frame_arbiter;

   localparam int CNT_W = 5;
   localparam int GAP   = 16;
   localparam int NUM_W = 10;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             push_a = 1'b0, push_b = 1'b0;
   logic [CNT_W-1:0] count_a, count_b;
   logic [7:0]       rdr_a, rdr_b;
   logic             pop_a, pop_b;
   logic [7:0]       cmd_data;
   logic             cmd_valid, cmd_last, sel, busy, frame_err;
   logic             cmd_ready = 1'b0;

   logic [7:0] dataA = 8'h00, dataB = 8'h00;
   bit         dropB = 1'b0;
   logic [7:0] fifoA[$], fifoB[$];

   int vectors = 0;
   int miscompares = 0;

   // monitor results
   logic [7:0] outData[$];
   bit         outLast[$];
   int         popsA, popsB, errs;
   int         stallAt = -1, stallLeft = 0;
   bit         holding = 1'b0;
   logic [7:0] heldData;
   logic       heldLast;

   // reference model state
   logic [7:0] frameA[$], frameB[$];
   int         nA, nB;
   logic [7:0] expData[$];
   bit         expLast[$];
   int         expPopsA, expPopsB, expErrs;
   logic       expSel = 1'b0;

   comm_frame_arbiter #(.CNT_W(CNT_W), .GAP_CYCLES(GAP), .NUM_W(NUM_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .push_a(push_a), .push_b(push_b),
      .count_a(count_a), .count_b(count_b),
      .rdr_a(rdr_a), .rdr_b(rdr_b),
      .pop_a(pop_a), .pop_b(pop_b),
      .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_last(cmd_last), .sel(sel), .busy(busy), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // UART RX FIFO models: count and head byte follow one clock after a push or pop.
   always @(posedge clk) begin
      if (pop_a && fifoA.size() > 0) void'(fifoA.pop_front());
      if (pop_b && fifoB.size() > 0) void'(fifoB.pop_front());
      if (push_a) fifoA.push_back(dataA);
      if (push_b && !dropB) fifoB.push_back(dataB);
      count_a <= CNT_W'(fifoA.size());
      count_b <= CNT_W'(fifoB.size());
      rdr_a   <= (fifoA.size() > 0) ? fifoA[0] : 8'h00;
      rdr_b   <= (fifoB.size() > 0) ? fifoB[0] : 8'h00;
   end

   // Command-side sink: drives cmd_ready, records accepted bytes, counts pops and
   // checks that a stalled byte stays put with no pop until it is taken.
   always @(negedge clk) begin
      if (!rst_n) begin
         holding = 1'b0;
      end else begin
         if (pop_a) popsA++;
         if (pop_b) popsB++;
         if (frame_err) errs++;
         if (pop_a || pop_b) begin
            vectors++;
            if ((pop_a && pop_b) || !busy) begin
               miscompares++;
               $display("[TB] FAIL pop legality: pop_a=%b pop_b=%b busy=%b, want single pop while busy", pop_a, pop_b, busy);
            end
         end
         if (holding) begin
            vectors++;
            if (cmd_valid !== 1'b1 || cmd_data !== heldData || cmd_last !== heldLast || pop_a || pop_b) begin
               miscompares++;
               $display("[TB] FAIL hold: got valid=%b data=%h last=%b pops=%b%b, want valid=1 data=%h last=%b pops=00",
                        cmd_valid, cmd_data, cmd_last, pop_a, pop_b, heldData, heldLast);
            end
         end
         if (stallLeft > 0 && cmd_valid && outData.size() == stallAt) begin
            cmd_ready = 1'b0;
            stallLeft--;
         end else begin
            cmd_ready = ($urandom_range(0, 3) != 0);
         end
         holding  = cmd_valid && !cmd_ready;
         heldData = cmd_data;
         heldLast = cmd_last;
         if (cmd_valid && cmd_ready) begin
            outData.push_back(cmd_data);
            outLast.push_back(cmd_last);
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got hang want completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // One push clock; consecutive calls leave one idle clock between pushes.
   task automatic applyStimulus(input bit pa, input logic [7:0] da, input bit pb, input logic [7:0] db);
      @(negedge clk);
      push_a = pa; dataA = da;
      push_b = pb; dataB = db;
      if (pa) begin nA++; frameA.push_back(da); end
      if (pb) begin nB++; if (!dropB) frameB.push_back(db); end
      @(negedge clk);
      push_a = 1'b0;
      push_b = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Frame-level reference: the port with more pushes wins (ties keep the previous
   // choice); its stored bytes come out in order, the other port's copy is discarded.
   task automatic modelFrame();
      if (nA > nB) expSel = 1'b0;
      else if (nB > nA) expSel = 1'b1;
      if (!expSel) begin
         if (frameA.size() == 0) expErrs++;
         foreach (frameA[i]) begin
            expData.push_back(frameA[i]);
            expLast.push_back(i == frameA.size() - 1);
         end
      end else begin
         if (frameB.size() == 0) expErrs++;
         foreach (frameB[i]) begin
            expData.push_back(frameB[i]);
            expLast.push_back(i == frameB.size() - 1);
         end
      end
      expPopsA += frameA.size();
      expPopsB += frameB.size();
      frameA.delete(); frameB.delete();
      nA = 0; nB = 0;
   endtask

   task automatic startScenario();
      outData.delete(); outLast.delete();
      expData.delete(); expLast.delete();
      frameA.delete(); frameB.delete();
      popsA = 0; popsB = 0; errs = 0;
      expPopsA = 0; expPopsB = 0; expErrs = 0;
      nA = 0; nB = 0;
   endtask

   task automatic waitDone(input string name);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL %s timeout: busy=%b after %0d clks, want 0", name, busy, n);
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({pop_a, pop_b, cmd_valid, cmd_last, sel, busy, frame_err} !== 7'b0) begin
         miscompares++;
         $display("[TB] FAIL reset outputs: got pops=%b%b valid=%b last=%b sel=%b busy=%b err=%b, want all 0",
                  pop_a, pop_b, cmd_valid, cmd_last, sel, busy, frame_err);
      end
      vectors++;
      if (cmd_data !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset cmd_data: got %h want 00", cmd_data);
      end
      rst_n = 1'b1;
      repeat (GAP + 4) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset idle: got busy=%b valid=%b want 0 0", busy, cmd_valid);
      end
   endtask

   task automatic test_tie();
      logic [7:0] b;
      startScenario();
      for (int i = 0; i < 5; i++) begin
         b = 8'($urandom);
         applyStimulus(1'b1, b, 1'b1, b);
         idleCycles($urandom_range(0, 3));
      end
      modelFrame();
      waitDone("tie");
      vectors++;
      if (sel !== expSel) begin miscompares++; $display("[TB] FAIL tie sel: got %b want %b", sel, expSel); end
      vectors++;
      if (outData.size() != expData.size()) begin miscompares++; $display("[TB] FAIL tie length: got %0d want %0d", outData.size(), expData.size()); end
      foreach (expData[i]) if (i < outData.size()) begin
         vectors++;
         if (outData[i] !== expData[i] || outLast[i] !== expLast[i]) begin
            miscompares++;
            $display("[TB] FAIL tie byte%0d: got %h/%b want %h/%b", i, outData[i], outLast[i], expData[i], expLast[i]);
         end
      end
      vectors++;
      if (popsA != expPopsA || popsB != expPopsB || errs != expErrs) begin
         miscompares++;
         $display("[TB] FAIL tie pops: got A=%0d B=%0d err=%0d want A=%0d B=%0d err=%0d", popsA, popsB, errs, expPopsA, expPopsB, expErrs);
      end
   endtask

   task automatic test_b_wins();
      startScenario();
      for (int i = 0; i < 6; i++) begin
         applyStimulus(i < 3, 8'($urandom), 1'b1, 8'($urandom));
         idleCycles($urandom_range(0, 4));
      end
      modelFrame();
      waitDone("b_wins");
      vectors++;
      if (sel !== expSel) begin miscompares++; $display("[TB] FAIL b_wins sel: got %b want %b", sel, expSel); end
      vectors++;
      if (outData.size() != expData.size()) begin miscompares++; $display("[TB] FAIL b_wins length: got %0d want %0d", outData.size(), expData.size()); end
      foreach (expData[i]) if (i < outData.size()) begin
         vectors++;
         if (outData[i] !== expData[i] || outLast[i] !== expLast[i]) begin
            miscompares++;
            $display("[TB] FAIL b_wins byte%0d: got %h/%b want %h/%b", i, outData[i], outLast[i], expData[i], expLast[i]);
         end
      end
      vectors++;
      if (popsA != expPopsA || popsB != expPopsB || fifoA.size() != 0 || fifoB.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL b_wins pops: got A=%0d B=%0d left=%0d/%0d want A=%0d B=%0d left=0/0",
                  popsA, popsB, fifoA.size(), fifoB.size(), expPopsA, expPopsB);
      end
   endtask

   task automatic test_stall();
      logic [7:0] b;
      startScenario();
      stallAt = 1;
      stallLeft = 50;
      for (int i = 0; i < 4; i++) begin
         b = 8'($urandom);
         applyStimulus(1'b1, b, 1'b1, b);
      end
      modelFrame();
      waitDone("stall");
      stallAt = -1;
      vectors++;
      if (stallLeft != 0) begin miscompares++; $display("[TB] FAIL stall applied: got %0d clks left want 0", stallLeft); end
      vectors++;
      if (outData.size() != expData.size()) begin miscompares++; $display("[TB] FAIL stall length: got %0d want %0d", outData.size(), expData.size()); end
      foreach (expData[i]) if (i < outData.size()) begin
         vectors++;
         if (outData[i] !== expData[i] || outLast[i] !== expLast[i]) begin
            miscompares++;
            $display("[TB] FAIL stall byte%0d: got %h/%b want %h/%b", i, outData[i], outLast[i], expData[i], expLast[i]);
         end
      end
      vectors++;
      if (popsA != expPopsA || popsB != expPopsB) begin
         miscompares++;
         $display("[TB] FAIL stall pops: got A=%0d B=%0d want A=%0d B=%0d", popsA, popsB, expPopsA, expPopsB);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      startScenario();
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 8'($urandom));
      modelFrame();
      n = 0;
      while (outData.size() == 0 && n < 500) begin @(negedge clk); n++; end
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00);
      modelFrame();
      waitDone("back_to_back");
      vectors++;
      if (sel !== expSel) begin miscompares++; $display("[TB] FAIL b2b sel: got %b want %b", sel, expSel); end
      vectors++;
      if (outData.size() != expData.size()) begin miscompares++; $display("[TB] FAIL b2b length: got %0d want %0d", outData.size(), expData.size()); end
      foreach (expData[i]) if (i < outData.size()) begin
         vectors++;
         if (outData[i] !== expData[i] || outLast[i] !== expLast[i]) begin
            miscompares++;
            $display("[TB] FAIL b2b byte%0d: got %h/%b want %h/%b", i, outData[i], outLast[i], expData[i], expLast[i]);
         end
      end
      vectors++;
      if (popsA != expPopsA || popsB != expPopsB || fifoA.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL b2b pops: got A=%0d B=%0d leftA=%0d want A=%0d B=%0d leftA=0", popsA, popsB, fifoA.size(), expPopsA, expPopsB);
      end
   endtask

   task automatic test_gap();
      startScenario();
      applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00);
      idleCycles(GAP - 3);
      applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00);
      modelFrame();
      waitDone("gap_short");
      applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00);
      modelFrame();
      idleCycles(GAP - 1);
      applyStimulus(1'b1, 8'($urandom), 1'b0, 8'h00);
      modelFrame();
      waitDone("gap_exact");
      vectors++;
      if (outData.size() != expData.size()) begin miscompares++; $display("[TB] FAIL gap length: got %0d want %0d", outData.size(), expData.size()); end
      foreach (expData[i]) if (i < outData.size()) begin
         vectors++;
         if (outData[i] !== expData[i] || outLast[i] !== expLast[i]) begin
            miscompares++;
            $display("[TB] FAIL gap byte%0d: got %h/%b want %h/%b", i, outData[i], outLast[i], expData[i], expLast[i]);
         end
      end
      vectors++;
      if (sel !== expSel || popsA != expPopsA || popsB != expPopsB) begin
         miscompares++;
         $display("[TB] FAIL gap sel/pops: got %b A=%0d B=%0d want %b A=%0d B=%0d", sel, popsA, popsB, expSel, expPopsA, expPopsB);
      end
   endtask

   task automatic test_frame_err();
      startScenario();
      dropB = 1'b1;
      applyStimulus(1'b1, 8'($urandom), 1'b1, 8'($urandom));
      applyStimulus(1'b0, 8'h00, 1'b1, 8'($urandom));
      dropB = 1'b0;
      modelFrame();
      waitDone("frame_err");
      vectors++;
      if (errs != expErrs || outData.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL frame_err pulse: got err=%0d out=%0d want err=%0d out=0", errs, outData.size(), expErrs);
      end
      vectors++;
      if (sel !== expSel || popsA != expPopsA || popsB != expPopsB || fifoA.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL frame_err flush: got sel=%b A=%0d B=%0d want sel=%b A=%0d B=%0d", sel, popsA, popsB, expSel, expPopsA, expPopsB);
      end
   endtask

   task automatic test_reset_mid();
      int n, pA, pB;
      startScenario();
      for (int i = 0; i < 4; i++) applyStimulus(i < 2, 8'($urandom), 1'b1, 8'($urandom));
      modelFrame();
      n = 0;
      while (cmd_valid !== 1'b1 && n < 500) begin @(negedge clk); n++; end
      vectors++;
      if (cmd_valid !== 1'b1 || sel !== expSel) begin
         miscompares++;
         $display("[TB] FAIL reset_mid present: got valid=%b sel=%b want 1 %b", cmd_valid, sel, expSel);
      end
      #2 rst_n = 1'b0;
      #1;
      vectors++;
      if ({pop_a, pop_b, cmd_valid, busy, sel} !== 5'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid outputs: got pops=%b%b valid=%b busy=%b sel=%b want all 0", pop_a, pop_b, cmd_valid, busy, sel);
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      pA = popsA;
      pB = popsB;
      repeat (GAP + 10) @(negedge clk);
      vectors++;
      if (popsA != pA || popsB != pB || cmd_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_mid after: got pops +%0d/+%0d valid=%b busy=%b want +0/+0 0 0",
                  popsA - pA, popsB - pB, cmd_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_tie();
      test_b_wins();
      test_stall();
      test_back_to_back();
      test_gap();
      test_frame_err();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
